// File: rtl/lc3_sram_responder_pkg.sv
// Shared types for the LC-3 SRAM responder: FSM states, bus operations,
// and the strobe decoder.
package lc3_mem_pkg;

   localparam int unsigned LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_READ,
      OP_WRITE
   } op_t;

   // A write wins when OE and WE are both low.
   function automatic op_t decode_op(input logic ce_n, input logic oe_n, input logic we_n);
      if (ce_n)  return OP_NONE;
      if (!we_n) return OP_WRITE;
      if (!oe_n) return OP_READ;
      return OP_NONE;
   endfunction

endpackage

// File: rtl/lc3_sram_responder_if.sv
// LC-3 SRAM bus: active-low strobes, address and data from the CPU side,
// plus the read data, bus-ownership flag and ready from the memory side.
interface lc3_sram_responder_if;

   logic        CE;
   logic        OE;
   logic        WE;
   logic        UB;
   logic        LB;
   logic [19:0] ADDR;
   logic [15:0] Data_from_cpu;
   logic [15:0] Data_to_cpu;
   logic        Data_drive;
   logic        R;

   modport master (
      output CE, OE, WE, UB, LB, ADDR, Data_from_cpu,
      input  Data_to_cpu, Data_drive, R
   );

   modport slave (
      input  CE, OE, WE, UB, LB, ADDR, Data_from_cpu,
      output Data_to_cpu, Data_drive, R
   );

endinterface

// File: rtl/lc3_sram_responder_sram_word_array.sv
// 16-bit word storage: one clocked write port with per-byte enables and an
// asynchronous read port.
module sram_word_array
   import lc3_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  ub_en,
   input  logic                  lb_en,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [2*LANE_W-1:0]   wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [2*LANE_W-1:0]   rdata
);

   logic [2*LANE_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         if (ub_en) mem[waddr][2*LANE_W-1:LANE_W] <= wdata[2*LANE_W-1:LANE_W];
         if (lb_en) mem[waddr][LANE_W-1:0]        <= wdata[LANE_W-1:0];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lc3_sram_responder.sv
// Memory-side responder for the LC-3 SRAM bus with programmable wait states
// and a preload port usable while the bus is idle.
module lc3_sram_responder
   import lc3_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   lc3_sram_responder_if.slave  bus,
   input  logic                 Init_we,
   input  logic [ADDR_W-1:0]    Init_addr,
   input  logic [15:0]          Init_data,
   output logic                 Init_rdy
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

   state_t              state;
   op_t                 op_q;
   op_t                 op_now;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         data_q;
   logic                ub_n_q;
   logic                lb_n_q;
   logic [3:0]          cnt;
   logic                r_q;
   logic                drive_q;
   logic [15:0]         rdata_q;
   logic                commit;

   logic                arr_we;
   logic                arr_ub;
   logic                arr_lb;
   logic [ADDR_W-1:0]   arr_waddr;
   logic [15:0]         arr_wdata;
   logic [15:0]         arr_rdata;

   assign op_now   = decode_op(bus.CE, bus.OE, bus.WE);
   assign commit   = (state == WAIT) && (op_now != OP_NONE) && (cnt == '0);
   assign Init_rdy = (state == IDLE);

   // Preload owns the write port in IDLE, the CPU commit owns it in WAIT.
   always_comb begin
      arr_we    = 1'b0;
      arr_ub    = 1'b0;
      arr_lb    = 1'b0;
      arr_waddr = addr_q;
      arr_wdata = data_q;
      if (!Reset) begin
         if (state == IDLE && Init_we) begin
            arr_we    = 1'b1;
            arr_ub    = 1'b1;
            arr_lb    = 1'b1;
            arr_waddr = Init_addr;
            arr_wdata = Init_data;
         end else if (commit && op_q == OP_WRITE) begin
            arr_we = 1'b1;
            arr_ub = ~ub_n_q;
            arr_lb = ~lb_n_q;
         end
      end
   end

   sram_word_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (Clk),
      .we    (arr_we),
      .ub_en (arr_ub),
      .lb_en (arr_lb),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .raddr (addr_q),
      .rdata (arr_rdata)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         r_q     <= 1'b0;
         drive_q <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_now != OP_NONE) begin
                  op_q   <= op_now;
                  addr_q <= bus.ADDR[ADDR_W-1:0];
                  data_q <= bus.Data_from_cpu;
                  ub_n_q <= bus.UB;
                  lb_n_q <= bus.LB;
                  cnt    <= CNT_INIT;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (op_now == OP_NONE) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state   <= ACK;
                  r_q     <= 1'b1;
                  drive_q <= (op_q == OP_READ);
                  if (op_q == OP_READ) begin
                     rdata_q <= {ub_n_q ? {LANE_W{1'b0}} : arr_rdata[2*LANE_W-1:LANE_W],
                                 lb_n_q ? {LANE_W{1'b0}} : arr_rdata[LANE_W-1:0]};
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK: begin
               if (op_now == OP_NONE) begin
                  state   <= IDLE;
                  r_q     <= 1'b0;
                  drive_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.R           = r_q;
   assign bus.Data_drive  = drive_q;
   assign bus.Data_to_cpu = rdata_q;

endmodule

// File: tb/tb_lc3_sram_responder.sv
// Bench for lc3_sram_responder: a 2-wait-state unit and a 0-wait-state unit
// sharing one stimulus bus, checked against an array model of the storage.
module tb_lc3_sram_responder;

   localparam int WS_A = 2;
   localparam int WS_B = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        ce_n, oe_n, we_n, ub_n, lb_n;
   logic [19:0] addr;
   logic [15:0] wdata;
   logic        init_we;
   logic [9:0]  init_addr;
   logic [15:0] init_data;
   logic        init_rdy_a, init_rdy_b;

   logic        obs_r, obs_drive, obs_init_rdy;
   logic [15:0] obs_rd;

   int checks = 0;
   int errors = 0;
   logic [15:0] model [1024];

   always #5 clk = ~clk;

   lc3_sram_responder_if ifa();
   lc3_sram_responder_if ifb();

   assign ifa.CE = sel ? 1'b1 : ce_n;
   assign ifb.CE = sel ? ce_n : 1'b1;
   assign ifa.OE = oe_n;            assign ifb.OE = oe_n;
   assign ifa.WE = we_n;            assign ifb.WE = we_n;
   assign ifa.UB = ub_n;            assign ifb.UB = ub_n;
   assign ifa.LB = lb_n;            assign ifb.LB = lb_n;
   assign ifa.ADDR = addr;          assign ifb.ADDR = addr;
   assign ifa.Data_from_cpu = wdata; assign ifb.Data_from_cpu = wdata;

   assign obs_r        = sel ? ifb.R : ifa.R;
   assign obs_drive    = sel ? ifb.Data_drive : ifa.Data_drive;
   assign obs_rd       = sel ? ifb.Data_to_cpu : ifa.Data_to_cpu;
   assign obs_init_rdy = sel ? init_rdy_b : init_rdy_a;

   lc3_sram_responder #(.ADDR_W(10), .WAIT_STATES(WS_A)) dut_a (
      .Clk(clk), .Reset(rst), .bus(ifa.slave),
      .Init_we(sel ? 1'b0 : init_we), .Init_addr(init_addr), .Init_data(init_data),
      .Init_rdy(init_rdy_a)
   );

   lc3_sram_responder #(.ADDR_W(10), .WAIT_STATES(WS_B)) dut_b (
      .Clk(clk), .Reset(rst), .bus(ifb.slave),
      .Init_we(sel ? init_we : 1'b0), .Init_addr(init_addr), .Init_data(init_data),
      .Init_rdy(init_rdy_b)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic bus_idle();
      ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
   endtask

   task automatic init_write(input logic [9:0] a, input logic [15:0] d, output logic rdy);
      init_we = 1'b1; init_addr = a; init_data = d;
      #2;
      rdy = obs_init_rdy;
      @(posedge clk); #1;
      init_we = 1'b0;
   endtask

   // Presents one request, waits for R, then drops it; lat is the edge index
   // (first edge seeing the request = 0) after which R was seen, -1 if never.
   task automatic access(input logic w_n, input logic o_n, input logic [19:0] a,
                         input logic [15:0] d, input logic u_n, input logic l_n,
                         output int lat, output logic [15:0] rd, output logic drv,
                         output logic r_after, output logic [15:0] rd_after);
      ce_n = 1'b0; we_n = w_n; oe_n = o_n; addr = a; wdata = d; ub_n = u_n; lb_n = l_n;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (obs_r === 1'b1) begin
            lat = i;
            break;
         end
      end
      rd  = obs_rd;
      drv = obs_drive;
      bus_idle();
      @(posedge clk); #1;
      r_after  = obs_r;
      rd_after = obs_rd;
   endtask

   task automatic test_reset();
      sel = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
      addr = '0; wdata = '0; bus_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ifa.R !== 1'b0 || ifb.R !== 1'b0) begin
         errors++; $display("FAIL reset_r: got %b/%b want 0/0", ifa.R, ifb.R);
      end
      checks++;
      if (ifa.Data_drive !== 1'b0 || ifb.Data_drive !== 1'b0) begin
         errors++; $display("FAIL reset_drive: got %b/%b want 0/0", ifa.Data_drive, ifb.Data_drive);
      end
      checks++;
      if (ifa.Data_to_cpu !== 16'h0000 || ifb.Data_to_cpu !== 16'h0000) begin
         errors++; $display("FAIL reset_data: got %h/%h want 0000/0000", ifa.Data_to_cpu, ifb.Data_to_cpu);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (init_rdy_a !== 1'b1 || init_rdy_b !== 1'b1) begin
         errors++; $display("FAIL reset_idle: init_rdy got %b/%b want 1/1", init_rdy_a, init_rdy_b);
      end
   endtask

   task automatic test_preload();
      logic rdy, drv, ra; logic [15:0] rd, rda; int lat;
      init_write(10'h005, 16'h1234, rdy);
      model[10'h005] = 16'h1234;
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL preload_rdy: got %b want 1", rdy); end
      access(1'b1, 1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (lat !== WS_A + 1) begin errors++; $display("FAIL preload_latency: got %0d want %0d", lat, WS_A + 1); end
      checks++;
      if (rd !== 16'h1234) begin errors++; $display("FAIL preload_data: got %h want 1234", rd); end
      checks++;
      if (drv !== 1'b1) begin errors++; $display("FAIL preload_drive: got %b want 1", drv); end
      checks++;
      if (ra !== 1'b0) begin errors++; $display("FAIL preload_r_drop: got %b want 0", ra); end
      checks++;
      if (rda !== 16'h1234) begin errors++; $display("FAIL preload_data_hold: got %h want 1234", rda); end
   endtask

   task automatic test_byte_write();
      logic rdy, drv, ra; logic [15:0] rd, rda; int lat;
      init_write(10'h010, 16'hAAAA, rdy);
      model[10'h010] = 16'hAAAA;
      access(1'b0, 1'b1, 20'h00010, 16'h5566, 1'b1, 1'b0, lat, rd, drv, ra, rda);
      model[10'h010][7:0] = 8'h66;
      checks++;
      if (lat !== WS_A + 1 || drv !== 1'b0) begin
         errors++; $display("FAIL byte_write_ack: got lat %0d drive %b want %0d 0", lat, drv, WS_A + 1);
      end
      access(1'b1, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== 16'hAA66) begin errors++; $display("FAIL byte_write_readback: got %h want AA66", rd); end
      access(1'b1, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b1, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== 16'hAA00) begin errors++; $display("FAIL byte_read_lane_mask: got %h want AA00", rd); end
   endtask

   task automatic test_abort();
      logic rdy, drv, ra, seen; logic [15:0] rd, rda; int lat;
      init_write(10'h020, 16'h0000, rdy);
      model[10'h020] = 16'h0000;
      ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'h00020; wdata = 16'hFFFF;
      ub_n = 1'b0; lb_n = 1'b0;
      seen = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (obs_r === 1'b1) seen = 1'b1; end
      bus_idle();
      repeat (4) begin @(posedge clk); #1; if (obs_r === 1'b1) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got R seen %b want 0", seen); end
      checks++;
      if (obs_init_rdy !== 1'b1) begin errors++; $display("FAIL abort_idle: init_rdy got %b want 1", obs_init_rdy); end
      access(1'b1, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL abort_no_write: got %h want 0000", rd); end
   endtask

   task automatic test_reset_midop();
      logic drv, ra; logic [15:0] rd, rda; int lat;
      ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'h00010; wdata = 16'h0000;
      ub_n = 1'b0; lb_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs_r !== 1'b0 || obs_drive !== 1'b0) begin
         errors++; $display("FAIL midop_reset_flags: got R %b drive %b want 0 0", obs_r, obs_drive);
      end
      checks++;
      if (obs_rd !== 16'h0000) begin errors++; $display("FAIL midop_reset_data: got %h want 0000", obs_rd); end
      checks++;
      if (obs_init_rdy !== 1'b1) begin errors++; $display("FAIL midop_reset_idle: init_rdy got %b want 1", obs_init_rdy); end
      rst = 1'b0; bus_idle();
      @(posedge clk); #1;
      access(1'b1, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== model[10'h010]) begin errors++; $display("FAIL midop_reset_contents: got %h want %h", rd, model[10'h010]); end
      access(1'b1, 1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== 16'h1234) begin errors++; $display("FAIL midop_reset_preload: got %h want 1234", rd); end
   endtask

   task automatic test_alias_priority();
      logic drv, ra; logic [15:0] rd, rda; int lat;
      access(1'b0, 1'b0, 20'h00403, 16'hBEEF, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      model[10'h003] = 16'hBEEF;
      checks++;
      if (lat !== WS_A + 1 || drv !== 1'b0) begin
         errors++; $display("FAIL priority_write_ack: got lat %0d drive %b want %0d 0", lat, drv, WS_A + 1);
      end
      access(1'b1, 1'b0, 20'h00003, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== 16'hBEEF) begin errors++; $display("FAIL alias_readback: got %h want BEEF", rd); end
   endtask

   task automatic test_random();
      logic rdy, drv, ra; logic [15:0] rd, rda, d, exp; int lat;
      logic [9:0] idx; logic [19:0] a; logic wr, u, l;
      for (int k = 0; k < 8; k++) begin
         d = 16'($urandom);
         init_write(10'(10'h100 + k), d, rdy);
         model[10'h100 + k] = d;
      end
      for (int n = 0; n < 24; n++) begin
         idx = 10'(10'h100 + $urandom_range(0, 7));
         a   = {10'($urandom_range(0, 1023)), idx};
         wr  = 1'($urandom_range(0, 1));
         u   = 1'($urandom_range(0, 1));
         l   = 1'($urandom_range(0, 1));
         d   = 16'($urandom);
         access(~wr, 1'b0, a, d, u, l, lat, rd, drv, ra, rda);
         checks++;
         if (lat !== WS_A + 1 || ra !== 1'b0) begin
            errors++; $display("FAIL rand_handshake: got lat %0d r_after %b want %0d 0", lat, ra, WS_A + 1);
         end
         if (wr) begin
            if (!u) model[idx][15:8] = d[15:8];
            if (!l) model[idx][7:0]  = d[7:0];
            checks++;
            if (drv !== 1'b0) begin errors++; $display("FAIL rand_write_drive: got %b want 0", drv); end
         end else begin
            exp = model[idx];
            if (u) exp[15:8] = 8'h00;
            if (l) exp[7:0]  = 8'h00;
            checks++;
            if (rd !== exp || drv !== 1'b1) begin
               errors++; $display("FAIL rand_read @%h: got %h drive %b want %h 1", a, rd, drv, exp);
            end
         end
      end
   endtask

   task automatic test_zero_wait();
      logic rdy, drv, ra; logic [15:0] rd, rda, v; int lat;
      sel = 1'b1;
      @(posedge clk); #1;
      v = 16'($urandom) | 16'h0101;
      init_write(10'h007, v, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL zw_preload_rdy: got %b want 1", rdy); end
      access(1'b1, 1'b0, 20'h00007, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (lat !== WS_B + 1) begin errors++; $display("FAIL zw_latency: got %0d want %0d", lat, WS_B + 1); end
      checks++;
      if (rd !== v || drv !== 1'b1) begin errors++; $display("FAIL zw_read: got %h drive %b want %h 1", rd, drv, v); end
      ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 20'h00007; ub_n = 1'b0; lb_n = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (obs_r === 1'b1) begin lat = i; break; end
      end
      init_we = 1'b1; init_addr = 10'h007; init_data = ~v;
      addr = 20'h00008;
      #2;
      checks++;
      if (obs_init_rdy !== 1'b0) begin errors++; $display("FAIL zw_init_in_ack: init_rdy got %b want 0", obs_init_rdy); end
      @(posedge clk); #1;
      init_we = 1'b0;
      checks++;
      if (lat !== WS_B + 1 || obs_r !== 1'b1 || obs_rd !== v) begin
         errors++; $display("FAIL zw_ack_hold: got lat %0d R %b data %h want %0d 1 %h", lat, obs_r, obs_rd, WS_B + 1, v);
      end
      bus_idle();
      @(posedge clk); #1;
      access(1'b1, 1'b0, 20'h00007, 16'h0000, 1'b0, 1'b0, lat, rd, drv, ra, rda);
      checks++;
      if (rd !== v) begin errors++; $display("FAIL zw_init_ignored: got %h want %h", rd, v); end
      sel = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_preload();
      test_byte_write();
      test_abort();
      test_reset_midop();
      test_alias_priority();
      test_random();
      test_zero_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_sram_responder.md
Name: lc3_sram_responder

Overview:
- Clocked memory-side responder for the LC-3 datapath's SRAM bus.
- Answers read and write requests on the active-low CE/OE/WE/UB/LB strobes with a configurable wait-state latency and a ready flag that feeds the control unit's memory-ready input.
- Sits opposite the processor in system simulation and on-chip memory builds.
- Provides a preload port so a bench or boot loader can place programs before Run.

Parameters:
- ADDR_W, 10, number of address bits used for storage; depth is 2^ADDR_W 16-bit words.
- WAIT_STATES, 2, extra cycles between request capture and the access commit (0..15).

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- CE  in  1  chip enable, active low.
- OE  in  1  output enable, active low.
- WE  in  1  write enable, active low.
- UB  in  1  upper byte lane enable, active low.
- LB  in  1  lower byte lane enable, active low.
- ADDR  in  20  word address; only ADDR[ADDR_W-1:0] is used.
- Data_from_cpu  in  16  write data.
- Data_to_cpu  out  16  read data, registered.
- Data_drive  out  1  high when the responder owns the data bus.
- R  out  1  memory ready to the control unit.
- Init_we  in  1  preload write strobe, active high.
- Init_addr  in  ADDR_W  preload address.
- Init_data  in  16  preload data.
- Init_rdy  out  1  high when a preload write is accepted this cycle.

Behaviour:
- Request decode:
  - Write request: CE=0 and WE=0. This takes priority if OE is also 0.
  - Read request: CE=0, OE=0, WE=1.
  - Otherwise: no request.
- FSM states: IDLE, WAIT, ACK.
- Reset, which wins over everything: state=IDLE, R=0, Data_drive=0, Data_to_cpu=16'h0000, counter=0. Storage contents are NOT cleared. Reset during WAIT aborts the access with no write.
- IDLE:
  - On a request, latch op, address, data, UB and LB; set counter=WAIT_STATES; go to WAIT.
  - Init_rdy=1 only in IDLE. An Init_we in IDLE writes Init_data to Init_addr at that edge. Init_we in other states is ignored.
  - If Init_we and a CPU request occur together in IDLE, both happen: the init write commits and the request is latched. The init write is visible to that request's read.
- WAIT:
  - If the request deasserts, return to IDLE with no access (abort).
  - Otherwise, if counter==0, commit the access and go to ACK. If not, decrement the counter.
  - Write commit: update only the lanes whose enable is low. UB covers [15:8], LB covers [7:0]. Both lanes high means the write is a no-op but is still acknowledged.
  - Read commit: Data_to_cpu receives the stored word, with each disabled lane forced to 8'h00.
- ACK:
  - R=1. Data_drive=1 for reads, 0 for writes.
  - Address and data changes are ignored.
  - Stay in ACK while the request is present. When it deasserts, go to IDLE, so R and Data_drive fall at that edge.
- Latency: request first sampled at edge 0 gives R=1 after edge WAIT_STATES+1, held until the request drops.
- Back-to-back requests need at least one IDLE cycle, and therefore one de-asserted cycle, between them.
- Addresses alias modulo 2^ADDR_W.
- Data_to_cpu holds its last value outside ACK.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state enum (IDLE, WAIT, ACK);
  - the op enum (OP_NONE, OP_READ, OP_WRITE);
  - a function that decodes the strobes into an op;
  - a constant for the lane width (8).
- One sub-module, sram_word_array: single clocked write port with two byte-enables, plus asynchronous read.
- The responder muxes the init and CPU writes into the array: the init write goes through in IDLE, the CPU commit in WAIT.

Test Plan:
- Preload: Init_we with addr 0x005, data 0x1234 -> Init_rdy=1. Then a read of ADDR 0x00005 (CE=0, OE=0, WE=1, UB=LB=0), WAIT_STATES=2 -> R=1 after the 3rd edge, Data_to_cpu=0x1234, Data_drive=1. Dropping CE -> R=0 after the next edge.
- Byte write: preload 0xAAAA at 0x010. Write 0x5566 with UB=1, LB=0 -> read back 0xAA66. Then read with LB=1 -> 0xAA00.
- Abort: raise CE during WAIT on a write of 0xFFFF to 0x020 (holding 0x0000) -> R never asserts, FSM returns to IDLE, and a later read returns 0x0000.
- Reset mid-operation: Reset=1 in WAIT -> next cycle R=0, Data_drive=0, Data_to_cpu=0x0000, state IDLE. Preloaded contents are still readable.
- Aliasing and priority: with ADDR_W=10, write 0xBEEF to ADDR 0x00403 with OE=WE=0 -> treated as a write. A read of 0x00003 returns 0xBEEF.
- Zero wait: WAIT_STATES=0 read -> R=1 after edge 1. Init_we asserted during ACK -> Init_rdy=0 and memory is unchanged.
